// File: rtl/region_scheduler_pkg.sv
// Shared definitions for the colour-detection blocks: region codes,
// scheduler state encoding, default frame geometry and column-band lookup.
package region_scheduler_pkg;

  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;
  localparam int CNT_W          = 17;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_DECIDE   = 3'd3,
    ST_DEBOUNCE = 3'd4
  } state_e;

  // Column band containing xPos; anything at or past the third boundary lands in the last band
  function automatic logic [1:0] regionOf(input logic [9:0] xPos, input logic [9:0] band);
    logic [11:0] xw;
    logic [11:0] bw;
    xw = {2'b00, xPos};
    bw = {2'b00, band};
    if (xw >= 12'd3 * bw)      return 2'd3;
    else if (xw >= 12'd2 * bw) return 2'd2;
    else if (xw >= bw)         return 2'd1;
    else                       return 2'd0;
  endfunction

endpackage

// File: rtl/region_counter.sv
// Per-region green-pixel tally that sticks at all-ones instead of wrapping.
module region_counter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // A clear restarts the tally and may count the current pixel; otherwise count up and saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/region_scheduler.sv
// Accumulates green pixels per column band over a frame, picks the dominant
// band and reports it once it has won several frames in a row.
module region_scheduler
  import region_scheduler_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int HEIGHT        = DEFAULT_HEIGHT,
  parameter int THRESHOLD     = 10,
  parameter int STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pix_valid,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       eh_verde,
  output logic [9:0] reg_min,
  output logic [9:0] reg_max,
  output logic [3:0] detected,
  output logic       hit_valid,
  output logic [1:0] hit_region,
  output logic       frame_done
);

  localparam logic [9:0]       BAND       = 10'(WIDTH / 4);
  localparam logic [9:0]       LAST_X     = 10'(WIDTH - 1);
  localparam logic [9:0]       LAST_Y     = 10'(HEIGHT - 1);
  localparam int               STW        = $clog2(STABLE_FRAMES + 1);
  localparam logic [STW-1:0]   STABLE_MAX = STW'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(THRESHOLD);

  state_e           r_state;
  logic [3:0]       r_detected;
  logic             r_hitValid;
  logic             r_frameDone;
  logic [1:0]       r_hitRegion;
  logic [STW-1:0]   r_stable;
  logic             r_prevValid;
  logic [1:0]       r_prevWinner;

  logic [1:0]       w_region;
  logic             w_isSof;
  logic             w_isLast;
  logic             w_clear;
  logic             w_count;
  logic [CNT_W-1:0] w_counts [4];
  logic [3:0]       w_qualify;
  logic             w_winValid;
  logic [1:0]       w_winner;
  logic [CNT_W-1:0] w_best;
  logic             w_sameWinner;
  logic [STW-1:0]   w_nextStable;
  logic             w_hit;

  assign w_region = regionOf(x, BAND);
  assign reg_min  = 10'(w_region) * BAND;
  assign reg_max  = reg_min + BAND - 10'd1;

  assign w_isSof  = pix_valid && (x == 10'd0) && (y == 10'd0);
  assign w_isLast = pix_valid && (x == LAST_X) && (y == LAST_Y);

  // The first pixel of a frame is counted in the same cycle that opens it
  assign w_count = enable && pix_valid && eh_verde &&
                   ((r_state == ST_ACCUM) || ((r_state == ST_WAIT_SOF) && w_isSof));
  assign w_clear = !enable || (r_state == ST_IDLE) || (r_state == ST_DEBOUNCE) ||
                   ((r_state == ST_ACCUM) && w_isSof);

  for (genvar k = 0; k < 4; k++) begin : g_counter
    region_counter #(.CNT_W(CNT_W)) u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_inc   (w_count && (w_region == 2'(k))),
      .o_count (w_counts[k])
    );
  end

  // Largest qualifying count wins; strict compare keeps the lowest index on ties
  always_comb begin
    w_qualify  = '0;
    w_winValid = 1'b0;
    w_winner   = 2'd0;
    w_best     = '0;
    for (int k = 0; k < 4; k++) begin
      w_qualify[k] = (w_counts[k] > THRESH);
      if (w_qualify[k] && (!w_winValid || (w_counts[k] > w_best))) begin
        w_winValid = 1'b1;
        w_winner   = 2'(k);
        w_best     = w_counts[k];
      end
    end
  end

  assign w_sameWinner = w_winValid && r_prevValid && (w_winner == r_prevWinner);

  // Run length of the current winner, saturating so a long run never re-fires
  always_comb begin
    w_nextStable = '0;
    if (w_sameWinner) begin
      w_nextStable = (r_stable == STABLE_MAX) ? r_stable : r_stable + STW'(1);
    end else if (w_winValid) begin
      w_nextStable = STW'(1);
    end
  end

  assign w_hit = (w_nextStable == STABLE_MAX) && !(w_sameWinner && (r_stable == STABLE_MAX));

  // Frame sequencing; debounce results are committed on entry to DEBOUNCE so the pulses are registered and visible there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_detected   <= '0;
      r_hitValid   <= 1'b0;
      r_frameDone  <= 1'b0;
      r_hitRegion  <= 2'd0;
      r_stable     <= '0;
      r_prevValid  <= 1'b0;
      r_prevWinner <= 2'd0;
    end else if (!enable) begin
      r_state      <= ST_IDLE;
      r_hitValid   <= 1'b0;
      r_frameDone  <= 1'b0;
      r_stable     <= '0;
      r_prevValid  <= 1'b0;
      r_prevWinner <= 2'd0;
    end else begin
      r_hitValid  <= 1'b0;
      r_frameDone <= 1'b0;
      case (r_state)
        ST_IDLE:     r_state <= ST_WAIT_SOF;
        ST_WAIT_SOF: if (w_isSof) r_state <= ST_ACCUM;
        ST_ACCUM:    if (w_isLast) r_state <= ST_DECIDE;
        ST_DECIDE: begin
          r_state      <= ST_DEBOUNCE;
          r_detected   <= w_qualify;
          r_stable     <= w_nextStable;
          r_prevValid  <= w_winValid;
          r_prevWinner <= w_winner;
          r_frameDone  <= 1'b1;
          r_hitValid   <= w_hit;
          if (w_hit) r_hitRegion <= w_winner;
        end
        ST_DEBOUNCE: r_state <= ST_WAIT_SOF;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign detected   = r_detected;
  assign hit_valid  = r_hitValid;
  assign hit_region = r_hitRegion;
  assign frame_done = r_frameDone;

endmodule
